// File: rtl/interp_3_seq.sv
// Streaming 3x frequency-domain linear interpolator: one pilot in, the pilot
// plus two interpolated points at 1/3 and 2/3 out, with valid/ready on both sides.
module interp_3_seq #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 16,
    parameter int CONST     = 21,
    parameter int SHIFT     = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  est_in,
    input  logic                 est_valid,
    input  logic                 est_last,
    output logic                 est_ready,
    output logic [OUT_WIDTH-1:0] interp_out,
    output logic                 interp_valid,
    output logic                 interp_last,
    input  logic                 interp_ready
);

    localparam int SW = IN_WIDTH + 2;
    localparam int PW = IN_WIDTH + 7;
    localparam logic signed [PW-1:0] CONST_W = PW'(CONST);

    typedef enum logic [2:0] {IDLE, WAIT, I1, I2, PIL} state_t;

    state_t                state_reg, state_next;
    logic [IN_WIDTH-1:0]   prev_reg, prev_next;
    logic [IN_WIDTH-1:0]   cur_reg, cur_next;
    logic                  lastf_reg, lastf_next;
    logic [OUT_WIDTH-1:0]  out_reg, out_next;
    logic                  valid_reg, valid_next;
    logic                  last_reg, last_next;

    logic                  adv;
    logic                  accept;
    logic signed [SW-1:0]  prev_x, cur_x, sum_sel;
    logic signed [PW-1:0]  prod;
    logic [OUT_WIDTH-1:0]  div_res;

    assign adv       = !valid_reg || interp_ready;
    assign est_ready = rst && adv && (state_reg == IDLE || state_reg == WAIT);
    assign accept    = est_valid && est_ready;

    // I1 weights prev twice, I2 weights cur twice; one shared multiplier serves both.
    assign prev_x  = SW'($signed(prev_reg));
    assign cur_x   = SW'($signed(cur_reg));
    assign sum_sel = (state_reg == I1) ? ((prev_x <<< 1) + cur_x)
                                       : (prev_x + (cur_x <<< 1));
    assign prod    = PW'(sum_sel) * CONST_W;
    assign div_res = OUT_WIDTH'(prod >>> SHIFT);

    always_comb begin
        state_next = state_reg;
        prev_next  = prev_reg;
        cur_next   = cur_reg;
        lastf_next = lastf_reg;
        out_next   = out_reg;
        valid_next = valid_reg;
        last_next  = last_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    prev_next  = est_in;
                    out_next   = est_in;
                    valid_next = 1'b1;
                    last_next  = est_last;
                    state_next = est_last ? IDLE : WAIT;
                end else if (adv) begin
                    valid_next = 1'b0;
                end
            end
            WAIT: begin
                if (accept) begin
                    cur_next   = est_in;
                    lastf_next = est_last;
                    valid_next = 1'b0;
                    state_next = I1;
                end else if (adv) begin
                    valid_next = 1'b0;
                end
            end
            I1: begin
                if (adv) begin
                    out_next   = div_res;
                    valid_next = 1'b1;
                    last_next  = 1'b0;
                    state_next = I2;
                end
            end
            I2: begin
                if (adv) begin
                    out_next   = div_res;
                    valid_next = 1'b1;
                    last_next  = 1'b0;
                    state_next = PIL;
                end
            end
            PIL: begin
                if (adv) begin
                    out_next   = cur_reg;
                    prev_next  = cur_reg;
                    valid_next = 1'b1;
                    last_next  = lastf_reg;
                    state_next = lastf_reg ? IDLE : WAIT;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            prev_reg  <= '0;
            cur_reg   <= '0;
            lastf_reg <= 1'b0;
            out_reg   <= '0;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            prev_reg  <= prev_next;
            cur_reg   <= cur_next;
            lastf_reg <= lastf_next;
            out_reg   <= out_next;
            valid_reg <= valid_next;
            last_reg  <= last_next;
        end
    end

    assign interp_out   = out_reg;
    assign interp_valid = valid_reg;
    assign interp_last  = last_reg;

endmodule

// File: tb/tb_interp_3_seq.sv
// Directed bench for interp_3_seq: hand-computed output sequences, backpressure
// hold checks and mid-interpolation reset.
module tb_interp_3_seq;

    logic               clk;
    logic               rst;
    logic signed [15:0] est_in;
    logic               est_valid;
    logic               est_last;
    logic               est_ready;
    logic signed [15:0] interp_out;
    logic               interp_valid;
    logic               interp_last;
    logic               interp_ready;

    int total = 0;
    int bad   = 0;

    logic [16:0] rx[$];
    int          exp_v[7];
    logic        tog = 1'b0;
    int          tog_k = 0;

    logic               prev_hold = 1'b0;
    logic               prev_rst  = 1'b0;
    logic signed [15:0] prev_out  = '0;
    logic               prev_last = 1'b0;

    interp_3_seq dut (
        .clk          (clk),
        .rst          (rst),
        .est_in       (est_in),
        .est_valid    (est_valid),
        .est_last     (est_last),
        .est_ready    (est_ready),
        .interp_out   (interp_out),
        .interp_valid (interp_valid),
        .interp_last  (interp_last),
        .interp_ready (interp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream ready pattern 1,0,0,1 repeating when enabled.
    always @(negedge clk) begin
        if (tog) begin
            interp_ready = (tog_k == 0 || tog_k == 3);
            tog_k = (tog_k + 1) % 4;
        end
    end

    // Capture accepted outputs and check that held outputs stay stable.
    always @(negedge clk) begin
        #3;
        if (rst && prev_rst && prev_hold) begin
            total++;
            assert (interp_out === prev_out && interp_last === prev_last) else begin
                bad++;
                $error("FAIL hold: out=%0d last=%0b required out=%0d last=%0b",
                       interp_out, interp_last, prev_out, prev_last);
            end
        end
        if (rst && interp_valid && interp_ready)
            rx.push_back({interp_last, interp_out});
        prev_hold = interp_valid && !interp_ready;
        prev_rst  = rst;
        prev_out  = interp_out;
        prev_last = interp_last;
    end

    task automatic send(input logic signed [15:0] v, input logic l);
        int n = 0;
        @(negedge clk);
        est_in = v;
        est_valid = 1'b1;
        est_last = l;
        #1;
        while (!est_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        total++;
        assert (n < 50) else begin
            bad++;
            $error("FAIL send_timeout: pilot=%0d waited=%0d required<50", v, n);
        end
        @(posedge clk);
        #1;
        est_valid = 1'b0;
        est_last = 1'b0;
    endtask

    task automatic check_seq(input string tag, input int n, input logic [6:0] lm);
        int w = 0;
        while (rx.size() < n && w < 200) begin
            @(posedge clk);
            w++;
        end
        repeat (6) @(posedge clk);
        #1;
        total++;
        assert (rx.size() == n) else begin
            bad++;
            $error("FAIL %s_count: got=%0d required=%0d", tag, rx.size(), n);
        end
        for (int i = 0; i < n; i++) begin
            if (i < rx.size()) begin
                total++;
                assert (rx[i][15:0] === 16'(exp_v[i]) && rx[i][16] === lm[i]) else begin
                    bad++;
                    $error("FAIL %s[%0d]: got=%0d last=%0b required=%0d last=%0b",
                           tag, i, $signed(rx[i][15:0]), rx[i][16], exp_v[i], lm[i]);
                end
            end
        end
        rx.delete();
    endtask

    task automatic chk_ready(input string tag, input logic req);
        total++;
        assert (est_ready === req) else begin
            bad++;
            $error("FAIL %s: est_ready=%0b required=%0b", tag, est_ready, req);
        end
    endtask

    initial begin
        rst = 1'b0;
        est_in = '0;
        est_valid = 1'b0;
        est_last = 1'b0;
        interp_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        total++;
        assert (interp_valid === 1'b0 && interp_out === 16'sd0 && interp_last === 1'b0) else begin
            bad++;
            $error("FAIL reset_out: valid=%0b out=%0d last=%0b required 0 0 0",
                   interp_valid, interp_out, interp_last);
        end
        chk_ready("reset_ready", 1'b0);
        rst = 1'b1;
        #1;
        chk_ready("idle_ready", 1'b1);
        rx.delete();

        // 96, 0 with est_ready low in I1/I2/PIL
        send(16'sd96, 1'b0);
        send(16'sd0, 1'b1);
        chk_ready("ready_i1", 1'b0);
        @(posedge clk); #1;
        chk_ready("ready_i2", 1'b0);
        @(posedge clk); #1;
        chk_ready("ready_pil", 1'b0);
        @(posedge clk); #1;
        chk_ready("ready_back_idle", 1'b1);
        exp_v = '{96, 63, 31, 0, 0, 0, 0};
        check_seq("pos", 4, 7'b0001000);

        // Negative values exercise floor rounding
        send(-16'sd96, 1'b0);
        send(16'sd0, 1'b1);
        exp_v = '{-96, -63, -32, 0, 0, 0, 0};
        check_seq("neg", 4, 7'b0001000);

        // Full scale
        send(16'sd32767, 1'b0);
        send(16'sd32767, 1'b1);
        exp_v = '{32767, 32255, 32255, 32767, 0, 0, 0};
        check_seq("full", 4, 7'b0001000);

        // Backpressure with toggling ready
        tog_k = 0;
        tog = 1'b1;
        send(16'sd96, 1'b0);
        send(16'sd0, 1'b0);
        send(16'sd96, 1'b1);
        exp_v = '{96, 63, 31, 0, 31, 63, 96};
        check_seq("bp", 7, 7'b1000000);
        tog = 1'b0;
        @(negedge clk);
        interp_ready = 1'b1;

        // Single-pilot symbols back to back
        send(16'sd50, 1'b1);
        chk_ready("single_ready_next", 1'b1);
        send(16'sd7, 1'b1);
        exp_v = '{50, 7, 0, 0, 0, 0, 0};
        check_seq("single", 2, 7'b0000011);

        // Reset while in I2
        send(16'sd96, 1'b0);
        send(16'sd0, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        assert (interp_valid === 1'b0 && interp_out === 16'sd0) else begin
            bad++;
            $error("FAIL midreset_out: valid=%0b out=%0d required 0 0",
                   interp_valid, interp_out);
        end
        chk_ready("midreset_ready", 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rx.delete();
        send(16'sd9, 1'b0);
        send(16'sd0, 1'b1);
        exp_v = '{9, 5, 2, 0, 0, 0, 0};
        check_seq("post_reset", 4, 7'b0001000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/interp_3_seq.md
Name: interp_3_seq

Overview:
- Streaming frequency-domain linear interpolator for the channel-estimation chain.
- Takes a stream of pilot channel estimates spaced 3 subcarriers apart and emits the full per-subcarrier estimate stream.
- Between each pair of pilots it inserts two points at 1/3 and 2/3, using the team's ×21 / >>>6 approximation of division by 3.
- Sits between the pilot LS estimator and the equaliser; a valid/ready handshake on both sides absorbs the 1-in/3-out rate change.

Parameters:
- IN_WIDTH, 16, signed pilot estimate width (I or Q component; instantiate twice for complex data).
- OUT_WIDTH, 16, signed output width; must equal IN_WIDTH.
- CONST, 21, reciprocal-of-3 multiplier.
- SHIFT, 6, right shift applied after multiplication.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- est_in  in  IN_WIDTH  signed pilot estimate
- est_valid  in  1  est_in valid
- est_last  in  1  marks the last pilot of a symbol; qualified by est_valid
- est_ready  out  1  block can accept a pilot
- interp_out  out  OUT_WIDTH  signed per-subcarrier estimate
- interp_valid  out  1  interp_out valid
- interp_last  out  1  marks the final output of a symbol
- interp_ready  in  1  downstream accepts interp_out

Behaviour:
- Reset (rst=0 at a clock edge) forces the following, regardless of the current state:
  - state=IDLE; interp_out=0, interp_valid=0, interp_last=0; est_ready=0 during reset.
  - Internal prev/cur registers cleared; an in-flight interpolation is discarded.
- Advance condition: adv = !interp_valid || interp_ready. Output registers load only when adv=1. With interp_valid=1 and interp_ready=0, interp_out and interp_last hold stable.
- est_ready = adv && (state==IDLE || state==WAIT). A pilot is accepted when est_valid && est_ready.
- FSM states and transitions:
  - IDLE: on accept, prev<=est_in, interp_out<=est_in, interp_valid<=1, interp_last<=est_last. Go to IDLE if est_last, else WAIT. With no accept and adv=1, interp_valid<=0.
  - WAIT: on accept, cur<=est_in, lastf<=est_last, output prev is already sent, go to I1. With no accept and adv=1, interp_valid<=0.
  - I1 (when adv): interp_out<=div3(2*prev+cur), interp_valid<=1, interp_last<=0, go to I2.
  - I2 (when adv): interp_out<=div3(prev+2*cur), interp_last<=0, go to PIL.
  - PIL (when adv): interp_out<=cur, prev<=cur, interp_last<=lastf. Go to IDLE if lastf, else WAIT.
- Latency:
  - Pilot accepted at edge N appears at interp_out/valid after edge N (visible in cycle N+1) in the IDLE case.
  - In the WAIT case, the first interpolated point appears one cycle after the I1 edge, i.e. 2 cycles after accept.
- Throughput: at most 1 pilot per 3 output cycles in steady state; est_ready is low in I1, I2 and PIL.
- Arithmetic for div3(s):
  - s is formed at IN_WIDTH+2 bits, sign-extended.
  - p = s*CONST at IN_WIDTH+7 bits.
  - Result = p >>> SHIFT (arithmetic shift, floor toward −inf), truncated to OUT_WIDTH.
  - No rounding and no saturation; the result magnitude is always ≤ 63/64 of full scale, so it never overflows.
- Single-pilot symbol (est_last on the first pilot): one output, interp_last=1, return to IDLE.
- est_last with est_valid=0 is ignored.
- A held output under backpressure must not drop or duplicate a value. The bench compares the full accepted-output sequence against a reference model.

Test Plan:
- Pilots 96, 0 (last on 0), interp_ready=1 → outputs 96, 63, 31, 0; interp_last only on the final 0; est_ready low during I1/I2/PIL.
- Pilots −96, 0 (last) → outputs −96, −63, −32, 0. This checks arithmetic floor: −2016>>>6 = −32.
- Pilots 32767, 32767 (last) → outputs 32767, 32255, 32255, 32767; no overflow.
- Pilots 96, 0, 96 (last), interp_ready toggling 1,0,0,1,… → accepted sequence is exactly 96, 63, 31, 0, 31, 63, 96; interp_out stable whenever valid=1 and ready=0.
- Single pilot 50 with est_last → one output 50 with interp_last=1; FSM returns to IDLE and accepts a new pilot next cycle.
- rst=0 asserted while in I2 → next cycle interp_valid=0, interp_out=0, est_ready=0. After release, pilots 9, 0 (last) yield 9, 5, 2, 0 with no stale data.
